mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access stage. It consumes the execute stage's registered outputs: ALU `result` as effective address, the `mem_read_enabled`/`mem_write_enabled` flags, and the writeback destination flags.
- It performs the single load or store against data memory through a request/acknowledge handshake, with byte-lane steering and sign/zero extension.
- It presents final writeback data plus forwarded register-write controls to the writeback stage.
- It sits between execute and writeback; the core controller holds `state == MEM` until `done` is seen.

Parameters:
- `ADDR_W`, 16, word-address width driven onto `mem_addr`; byte address bits `[ADDR_W+1:2]` are used.
- `TIMEOUT`, 255, max cycles waiting for `mem_ack` before abort; 0 disables timeout.

Ports:
- `clk` input 1: clock.
- `rstn` input 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `state` input 3: core state; block is active only when `state == MEM`.
- `instr` input `instructions`: decoded instruction; uses `lb`, `lh`, `lw`, `lbu`, `lhu`, `flw`, `sb`, `sh`, `sw`, `fsw`.
- `result` input 32: execute result; the byte address for memory ops, otherwise the writeback value.
- `rs2_v` input 32: integer store data.
- `frs2_v` input 32: float store data (`fsw`).
- `mem_read_enabled` input 1: from execute.
- `mem_write_enabled` input 1: from execute.
- `reg_write_enabled_in` input 1: integer writeback enable from execute.
- `freg_write_enabled_in` input 1: float writeback enable from execute.
- `write_dest_in` input 5: destination register.
- `mem_req` output 1: memory request, held until ack.
- `mem_we` output 4: byte write enables; 0000 for reads.
- `mem_addr` output `ADDR_W`: word address.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_ack` input 1: memory acknowledge; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata` input 32: read word.
- `wb_data` output 32: writeback value.
- `reg_write_enabled` output 1: integer writeback enable to writeback stage.
- `freg_write_enabled` output 1: float writeback enable to writeback stage.
- `write_dest` output 5: destination register to writeback stage.
- `done` output 1: stage complete (level).
- `misaligned` output 1: sticky for the current instruction.
- `bus_error` output 1: timeout abort for the current instruction.

Behaviour:
- Reset (`rstn` low at a posedge): FSM goes to IDLE. Every output is 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `wb_data`, both enables, `write_dest`, `done`, `misaligned`, `bus_error`.
- Reset mid-transaction drops `mem_req` at that edge; the memory must tolerate an abandoned request.
- FSM states: IDLE, REQ, DONE.
- IDLE, when `state == MEM`, latches the inputs and clears the error flags:
  - Load/store, aligned → REQ. `mem_req` = 1 from the next cycle; `mem_addr`/`mem_we`/`mem_wdata` are valid in that same cycle.
  - No memory op → DONE. `wb_data = result`, enables forwarded.
  - Misaligned → DONE with `misaligned = 1`, both write enables forced 0, no memory access.
- Alignment rules:
  - Word ops (`lw`, `flw`, `sw`, `fsw`) need addr[1:0] = 0.
  - Half ops need addr[0] = 0.
  - Byte ops are always aligned.
- REQ: hold `mem_req` and all bus outputs stable until `mem_ack`.
  - On ack: `mem_req` → 0 and go to DONE.
  - For loads, `wb_data` = the extracted value computed from `mem_rdata` in the ack cycle.
  - For stores, `wb_data = 0` and both enables are 0.
- Timeout: counter increments each REQ cycle. If it reaches `TIMEOUT` (nonzero) without ack, drop `mem_req`, set `bus_error = 1`, force enables 0, and go to DONE.
- Ack arriving in the same cycle the count hits `TIMEOUT` counts as success.
- DONE: `done = 1`, outputs hold. Return to IDLE when `state != MEM`, clearing `done`. Minimum latency with a 1-cycle ack: IDLE → REQ → DONE, so `done` is high 2 cycles after MEM entry.
- Store steering, little-endian, k = addr[1:0]:
  - `sb`: wdata = {4{byte}}, we = 1 << k.
  - `sh`: wdata = {2{half}}, we = 0011 or 1100.
  - `sw`/`fsw`: we = 1111. Data comes from `frs2_v` for `fsw`, else `rs2_v`.
- Load extraction:
  - `lb`/`lh`: select the lane, then sign-extend.
  - `lbu`/`lhu`: select the lane, then zero-extend.
  - `lw`/`flw`: full word.
- Forwarding: `freg_write_enabled` passes through for `flw`; `reg_write_enabled` passes through for integer loads.

Decomposition:
- Shared package `def.sv` holds the `MEM` state constant and the `instructions` struct; add the `mem_fsm_t` enum there.
- One natural sub-module, `lane_steer`: combinational store replication/byte-enable generation and load extract/extend, keyed by size/signedness and addr[1:0].

Test Plan:
- `sb` to addr 0x00000103 with `rs2_v` = 0x000000A5, ack after 3 cycles → `mem_addr` = 0x40, `mem_we` = 1000, `mem_wdata` = 0xA5A5A5A5, `mem_req` held 3 cycles, `done` set, `reg_write_enabled` = 0.
- `lh` from addr 0x0006 with `mem_rdata` = 0x8001_1234 → `wb_data` = 0xFFFF8001; `lhu` same → 0x00008001; `lbu` addr 0x0004 → 0x00000034.
- `flw` addr 0x0010, `rdata` = 0x3F800000 → `wb_data` = 0x3F800000, `freg_write_enabled` = 1, `reg_write_enabled` = 0.
- `lw` addr 0x0002 → no `mem_req` ever, `misaligned` = 1, `done` next cycle, both enables 0.
- `TIMEOUT` = 4, `sw` with ack never asserted → `mem_req` high exactly 4 cycles, then `bus_error` = 1, `done` = 1.
- `rstn` low during REQ → `mem_req` = 0 at that edge, all outputs 0. A following ALU op with `result` = 0x12345678 → `wb_data` = 0x12345678, `done` one cycle after MEM entry.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: core state code, decoded instruction
// flags, FSM encoding and access-size helpers.
package mem_access_pkg;

  localparam logic [2:0] MEM = 3'd3;

  typedef struct packed {
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic flw;
    logic sb;
    logic sh;
    logic sw;
    logic fsw;
  } instructions;

  typedef logic [1:0] mem_fsm_t;
  localparam mem_fsm_t FsmIdle = 2'd0;
  localparam mem_fsm_t FsmReq  = 2'd1;
  localparam mem_fsm_t FsmDone = 2'd2;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } mem_size_t;

  function automatic mem_size_t op_size(instructions i);
    if (i.lw || i.flw || i.sw || i.fsw) return SzWord;
    if (i.lh || i.lhu || i.sh) return SzHalf;
    return SzByte;
  endfunction

  function automatic logic is_aligned(mem_size_t sz, logic [1:0] off);
    case (sz)
      SzWord:  return off == 2'b00;
      SzHalf:  return !off[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/acknowledge data-memory bus between the memory-access stage and data memory.
interface mem_access_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_lane_steer.sv
// Little-endian byte-lane steering: store replication / byte enables and load
// lane extraction with sign or zero extension.
module mem_access_lane_steer
  import mem_access_pkg::*;
(
  input  mem_size_t   size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  we,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{offset, 3'b000} +: 8];
  assign rd_half = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    we        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SzByte: begin
        we        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sign_ext & rd_byte[7]}}, rd_byte};
      end
      SzHalf: begin
        we        = offset[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{sign_ext & rd_half[15]}}, rd_half};
      end
      default: begin
        we        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: one load or store per MEM visit over a req/ack bus,
// with alignment checking, ack timeout and writeback forwarding.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [2:0]   state,
  input  instructions  instr,
  input  logic [31:0]  result,
  input  logic [31:0]  rs2_v,
  input  logic [31:0]  frs2_v,
  input  logic         mem_read_enabled,
  input  logic         mem_write_enabled,
  input  logic         reg_write_enabled_in,
  input  logic         freg_write_enabled_in,
  input  logic [4:0]   write_dest_in,
  mem_access_if.master mem,
  output logic [31:0]  wb_data,
  output logic         reg_write_enabled,
  output logic         freg_write_enabled,
  output logic [4:0]   write_dest,
  output logic         done,
  output logic         misaligned,
  output logic         bus_error
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  mem_fsm_t          fsm_q, fsm_d;
  logic              req_q, req_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       wb_q, wb_d;
  logic              reg_we_q, reg_we_d;
  logic              freg_we_q, freg_we_d;
  logic [4:0]        dest_q, dest_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_read_q, is_read_d;
  mem_size_t         size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        off_q, off_d;
  logic              reg_in_q, reg_in_d;
  logic              freg_in_q, freg_in_d;

  mem_size_t   cur_size;
  logic        cur_sgn;
  logic        mem_op;
  logic        in_idle;
  logic [CntW-1:0] cnt_inc;
  logic        timeout_hit;
  logic [31:0] store_data;

  mem_size_t   steer_size;
  logic        steer_sgn;
  logic [1:0]  steer_off;
  logic [3:0]  steer_we;
  logic [31:0] steer_wdata;
  logic [31:0] load_data;

  logic unused_instr;
  assign unused_instr = instr.lbu ^ instr.sb;

  assign cur_size    = op_size(instr);
  assign cur_sgn     = instr.lb | instr.lh;
  assign mem_op      = mem_read_enabled | mem_write_enabled;
  assign store_data  = instr.fsw ? frs2_v : rs2_v;
  assign in_idle     = fsm_q == FsmIdle;
  assign cnt_inc     = cnt_q + CntW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CntW'(TIMEOUT));

  // Store steering uses the live inputs in IDLE; load extraction uses the latched op.
  assign steer_size = in_idle ? cur_size : size_q;
  assign steer_sgn  = in_idle ? cur_sgn : sgn_q;
  assign steer_off  = in_idle ? result[1:0] : off_q;

  mem_access_lane_steer u_lane_steer (
    .size       (steer_size),
    .sign_ext   (steer_sgn),
    .offset     (steer_off),
    .store_data (store_data),
    .rdata      (mem.mem_rdata),
    .we         (steer_we),
    .wdata      (steer_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    fsm_d     = fsm_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wb_d      = wb_q;
    reg_we_d  = reg_we_q;
    freg_we_d = freg_we_q;
    dest_d    = dest_q;
    done_d    = done_q;
    mis_d     = mis_q;
    berr_d    = berr_q;
    cnt_d     = cnt_q;
    is_read_d = is_read_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    off_d     = off_q;
    reg_in_d  = reg_in_q;
    freg_in_d = freg_in_q;

    case (fsm_q)
      FsmIdle: begin
        if (state == MEM) begin
          mis_d     = 1'b0;
          berr_d    = 1'b0;
          dest_d    = write_dest_in;
          is_read_d = mem_read_enabled;
          size_d    = cur_size;
          sgn_d     = cur_sgn;
          off_d     = result[1:0];
          reg_in_d  = reg_write_enabled_in;
          freg_in_d = freg_write_enabled_in;
          cnt_d     = '0;
          if (!mem_op) begin
            wb_d      = result;
            reg_we_d  = reg_write_enabled_in;
            freg_we_d = freg_write_enabled_in;
            done_d    = 1'b1;
            fsm_d     = FsmDone;
          end else if (!is_aligned(cur_size, result[1:0])) begin
            mis_d     = 1'b1;
            wb_d      = '0;
            reg_we_d  = 1'b0;
            freg_we_d = 1'b0;
            done_d    = 1'b1;
            fsm_d     = FsmDone;
          end else begin
            req_d     = 1'b1;
            addr_d    = result[ADDR_W+1:2];
            we_d      = mem_read_enabled ? 4'b0000 : steer_we;
            wdata_d   = mem_read_enabled ? 32'h0 : steer_wdata;
            wb_d      = '0;
            reg_we_d  = 1'b0;
            freg_we_d = 1'b0;
            fsm_d     = FsmReq;
          end
        end
      end
      FsmReq: begin
        // Ack wins over a timeout landing in the same cycle.
        if (mem.mem_ack) begin
          req_d  = 1'b0;
          done_d = 1'b1;
          fsm_d  = FsmDone;
          if (is_read_q) begin
            wb_d      = load_data;
            reg_we_d  = reg_in_q;
            freg_we_d = freg_in_q;
          end
        end else if (timeout_hit) begin
          req_d  = 1'b0;
          berr_d = 1'b1;
          done_d = 1'b1;
          fsm_d  = FsmDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FsmDone: begin
        if (state != MEM) begin
          done_d = 1'b0;
          fsm_d  = FsmIdle;
        end
      end
      default: fsm_d = FsmIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm_q     <= FsmIdle;
      req_q     <= 1'b0;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wb_q      <= '0;
      reg_we_q  <= 1'b0;
      freg_we_q <= 1'b0;
      dest_q    <= '0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      cnt_q     <= '0;
      is_read_q <= 1'b0;
      size_q    <= SzByte;
      sgn_q     <= 1'b0;
      off_q     <= '0;
      reg_in_q  <= 1'b0;
      freg_in_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wb_q      <= wb_d;
      reg_we_q  <= reg_we_d;
      freg_we_q <= freg_we_d;
      dest_q    <= dest_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
      cnt_q     <= cnt_d;
      is_read_q <= is_read_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      off_q     <= off_d;
      reg_in_q  <= reg_in_d;
      freg_in_q <= freg_in_d;
    end
  end

  assign mem.mem_req       = req_q;
  assign mem.mem_we        = we_q;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wdata     = wdata_q;
  assign wb_data           = wb_q;
  assign reg_write_enabled = reg_we_q;
  assign freg_write_enabled = freg_we_q;
  assign write_dest        = dest_q;
  assign done              = done_q;
  assign misaligned        = mis_q;
  assign bus_error         = berr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected results queued at issue, compared when done rises.
module tb_mem_access;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [2:0]  state;
  instructions instr;
  logic [31:0] result, rs2_v, frs2_v;
  logic        mem_read_enabled, mem_write_enabled;
  logic        reg_write_enabled_in, freg_write_enabled_in;
  logic [4:0]  write_dest_in;
  logic [31:0] wb_data;
  logic        reg_write_enabled, freg_write_enabled;
  logic [4:0]  write_dest;
  logic        done, misaligned, bus_error;

  mem_access_if #(.ADDR_W(16)) bus ();

  mem_access #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .state                 (state),
    .instr                 (instr),
    .result                (result),
    .rs2_v                 (rs2_v),
    .frs2_v                (frs2_v),
    .mem_read_enabled      (mem_read_enabled),
    .mem_write_enabled     (mem_write_enabled),
    .reg_write_enabled_in  (reg_write_enabled_in),
    .freg_write_enabled_in (freg_write_enabled_in),
    .write_dest_in         (write_dest_in),
    .mem                   (bus),
    .wb_data               (wb_data),
    .reg_write_enabled     (reg_write_enabled),
    .freg_write_enabled    (freg_write_enabled),
    .write_dest            (write_dest),
    .done                  (done),
    .misaligned            (misaligned),
    .bus_error             (bus_error)
  );

  typedef struct {
    logic [31:0] wb;
    logic        reg_we;
    logic        freg_we;
    logic [4:0]  dest;
    logic        mis;
    logic        berr;
    logic [15:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          reqs;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] wb, input logic reg_we, freg_we,
                              input logic [4:0] dest, input logic mis, berr,
                              input logic [15:0] addr, input logic [3:0] we,
                              input logic [31:0] wdata, input logic chk_wdata,
                              input int reqs, lat);
    exp_t e;
    e.wb = wb; e.reg_we = reg_we; e.freg_we = freg_we; e.dest = dest;
    e.mis = mis; e.berr = berr; e.addr = addr; e.we = we; e.wdata = wdata;
    e.chk_wdata = chk_wdata; e.reqs = reqs; e.lat = lat;
    return e;
  endfunction

  function automatic instructions ins_of(input string op);
    instructions i;
    i = '0;
    case (op)
      "lb":  i.lb = 1'b1;
      "lh":  i.lh = 1'b1;
      "lw":  i.lw = 1'b1;
      "lbu": i.lbu = 1'b1;
      "lhu": i.lhu = 1'b1;
      "flw": i.flw = 1'b1;
      "sb":  i.sb = 1'b1;
      "sh":  i.sh = 1'b1;
      "sw":  i.sw = 1'b1;
      "fsw": i.fsw = 1'b1;
      default: i = '0;
    endcase
    return i;
  endfunction

  task automatic check_zero(input string pfx);
    check({pfx, "_req"}, 32'(bus.mem_req), 32'h0);
    check({pfx, "_we"}, 32'(bus.mem_we), 32'h0);
    check({pfx, "_addr"}, 32'(bus.mem_addr), 32'h0);
    check({pfx, "_wdata"}, bus.mem_wdata, 32'h0);
    check({pfx, "_wb"}, wb_data, 32'h0);
    check({pfx, "_flags"},
          32'({reg_write_enabled, freg_write_enabled, write_dest, done, misaligned, bus_error}),
          32'h0);
  endtask

  // ack_after: ack in that REQ cycle (1 = first); 0 = never ack.
  task automatic run_op(input string op, input logic [31:0] res, rs2, frs2,
                        input logic regin, fregin, input logic [4:0] dest,
                        input logic [31:0] rdata, input int ack_after, input exp_t e);
    instructions ins;
    int lat, reqs;
    bit seen_done, unstable;
    logic [15:0] a;
    logic [3:0] w;
    logic [31:0] wd;
    exp_t x;
    ins = ins_of(op);
    sb_q.push_back(e);
    @(negedge clk);
    instr = ins; result = res; rs2_v = rs2; frs2_v = frs2;
    mem_read_enabled  = ins.lb | ins.lh | ins.lw | ins.lbu | ins.lhu | ins.flw;
    mem_write_enabled = ins.sb | ins.sh | ins.sw | ins.fsw;
    reg_write_enabled_in = regin; freg_write_enabled_in = fregin; write_dest_in = dest;
    state = MEM;
    lat = 0; reqs = 0; seen_done = 0; unstable = 0; a = '0; w = '0; wd = '0;
    while (!seen_done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen_done = 1;
      end else if (bus.mem_req) begin
        reqs++;
        if (reqs == 1) begin
          a = bus.mem_addr; w = bus.mem_we; wd = bus.mem_wdata;
        end else if (bus.mem_addr !== a || bus.mem_we !== w || bus.mem_wdata !== wd) begin
          unstable = 1;
        end
        if (reqs == ack_after) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
        end else begin
          bus.mem_ack = 1'b0; bus.mem_rdata = 32'hDEAD_DEAD;
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
    end
    bus.mem_ack = 1'b0;
    x = sb_q.pop_front();
    check({op, "_done_seen"}, 32'(seen_done), 32'h1);
    check({op, "_latency"}, 32'(lat), 32'(x.lat));
    check({op, "_req_cycles"}, 32'(reqs), 32'(x.reqs));
    check({op, "_req_low"}, 32'(bus.mem_req), 32'h0);
    check({op, "_wb"}, wb_data, x.wb);
    check({op, "_reg_we"}, 32'(reg_write_enabled), 32'(x.reg_we));
    check({op, "_freg_we"}, 32'(freg_write_enabled), 32'(x.freg_we));
    check({op, "_dest"}, 32'(write_dest), 32'(x.dest));
    check({op, "_misaligned"}, 32'(misaligned), 32'(x.mis));
    check({op, "_bus_error"}, 32'(bus_error), 32'(x.berr));
    if (x.reqs != 0) begin
      check({op, "_addr"}, 32'(a), 32'(x.addr));
      check({op, "_we"}, 32'(w), 32'(x.we));
      check({op, "_stable"}, 32'(unstable), 32'h0);
      if (x.chk_wdata) check({op, "_wdata"}, wd, x.wdata);
    end
    state = 3'd0;
    @(negedge clk);
    check({op, "_done_clear"}, 32'(done), 32'h0);
  endtask

  initial begin
    rstn = 1'b0; state = 3'd0; instr = '0; result = '0; rs2_v = '0; frs2_v = '0;
    mem_read_enabled = 1'b0; mem_write_enabled = 1'b0;
    reg_write_enabled_in = 1'b0; freg_write_enabled_in = 1'b0; write_dest_in = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;

    run_op("sb", 32'h103, 32'hA5, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0, 3,
           mk(32'h0, 0, 0, 5'd3, 0, 0, 16'h40, 4'b1000, 32'hA5A5A5A5, 1, 3, 4));
    run_op("sb", 32'h101, 32'h1234567C, 32'h0, 1'b0, 1'b0, 5'd4, 32'h0, 1,
           mk(32'h0, 0, 0, 5'd4, 0, 0, 16'h40, 4'b0010, 32'h7C7C7C7C, 1, 1, 2));
    run_op("lh", 32'h6, 32'h0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h80011234, 1,
           mk(32'hFFFF8001, 1, 0, 5'd5, 0, 0, 16'h1, 4'b0000, 32'h0, 0, 1, 2));
    run_op("lhu", 32'h6, 32'h0, 32'h0, 1'b1, 1'b0, 5'd6, 32'h80011234, 1,
           mk(32'h00008001, 1, 0, 5'd6, 0, 0, 16'h1, 4'b0000, 32'h0, 0, 1, 2));
    run_op("lbu", 32'h4, 32'h0, 32'h0, 1'b1, 1'b0, 5'd8, 32'h80011234, 1,
           mk(32'h00000034, 1, 0, 5'd8, 0, 0, 16'h1, 4'b0000, 32'h0, 0, 1, 2));
    run_op("lb", 32'h7, 32'h0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h80011234, 2,
           mk(32'hFFFFFF80, 1, 0, 5'd9, 0, 0, 16'h1, 4'b0000, 32'h0, 0, 2, 3));
    run_op("flw", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 5'd10, 32'h3F800000, 1,
           mk(32'h3F800000, 0, 1, 5'd10, 0, 0, 16'h4, 4'b0000, 32'h0, 0, 1, 2));
    run_op("lw", 32'h2, 32'h0, 32'h0, 1'b1, 1'b0, 5'd11, 32'h0, 1,
           mk(32'h0, 0, 0, 5'd11, 1, 0, 16'h0, 4'b0000, 32'h0, 0, 0, 1));
    run_op("sh", 32'hE, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 5'd12, 32'h0, 2,
           mk(32'h0, 0, 0, 5'd12, 0, 0, 16'h3, 4'b1100, 32'hBEEFBEEF, 1, 2, 3));
    run_op("sh", 32'h21, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 5'd13, 32'h0, 1,
           mk(32'h0, 0, 0, 5'd13, 1, 0, 16'h0, 4'b0000, 32'h0, 0, 0, 1));
    run_op("fsw", 32'h20, 32'h11111111, 32'h40490FDB, 1'b0, 1'b0, 5'd14, 32'h0, 1,
           mk(32'h0, 0, 0, 5'd14, 0, 0, 16'h8, 4'b1111, 32'h40490FDB, 1, 1, 2));
    run_op("sw", 32'h24, 32'h55AA33CC, 32'h0, 1'b0, 1'b0, 5'd15, 32'h0, 0,
           mk(32'h0, 0, 0, 5'd15, 0, 1, 16'h9, 4'b1111, 32'h55AA33CC, 1, 4, 5));
    run_op("lw", 32'h30, 32'h0, 32'h0, 1'b1, 1'b0, 5'd16, 32'hCAFEBABE, 4,
           mk(32'hCAFEBABE, 1, 0, 5'd16, 0, 0, 16'hC, 4'b0000, 32'h0, 0, 4, 5));
    run_op("alu", 32'h0BADF00D, 32'h0, 32'h0, 1'b1, 1'b0, 5'd7, 32'h0, 0,
           mk(32'h0BADF00D, 1, 0, 5'd7, 0, 0, 16'h0, 4'b0000, 32'h0, 0, 0, 1));

    // Reset while a request is outstanding.
    @(negedge clk);
    instr = ins_of("lw"); result = 32'h40; mem_read_enabled = 1'b1; mem_write_enabled = 1'b0;
    reg_write_enabled_in = 1'b1; write_dest_in = 5'd17; state = MEM;
    @(negedge clk);
    check("rst_req_before", 32'(bus.mem_req), 32'h1);
    rstn = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    rstn = 1'b1; state = 3'd0;
    @(negedge clk);
    check("rst_idle_done", 32'(done), 32'h0);
    run_op("alu", 32'h12345678, 32'h0, 32'h0, 1'b1, 1'b0, 5'd2, 32'h0, 0,
           mk(32'h12345678, 1, 0, 5'd2, 0, 0, 16'h0, 4'b0000, 32'h0, 0, 0, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
